// File: rtl/rsa_pipe_pkg.sv
// Shared types and field positions for the RSA five-stage pipeline core.
package rsa_pipe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_ORR   = 3'b011,
    ALU_EOR   = 3'b100,
    ALU_LSL   = 3'b101,
    ALU_LSR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int RN_LSB = 16;
  localparam int RD_LSB = 12;
  localparam int RM_LSB = 0;
  localparam int IMM_W  = 12;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: EX operand forward selects plus the
// stall/flush pair that inserts a bubble between ID and EX.
module hazard_unit
  import rsa_pipe_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [3:0] RnD,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_sel_e   ForwardAE,
  output fwd_sel_e   ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE
);

  logic hazard;
  logic match_e;
  logic match_m;

  assign match_e = (WA3E == RnD) || (WA3E == RA2D);
  assign match_m = (WA3M == RnD) || (WA3M == RA2D);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    hazard    = 1'b0;
    if (FWD_EN != 0) begin
      if (RegWriteM && (WA3M == RA1E))      ForwardAE = FWD_MEM;
      else if (RegWriteW && (WA3W == RA1E)) ForwardAE = FWD_WB;
      if (RegWriteM && (WA3M == RA2E))      ForwardBE = FWD_MEM;
      else if (RegWriteW && (WA3W == RA2E)) ForwardBE = FWD_WB;
      hazard = MemtoRegE && RegWriteE && match_e;
    end else begin
      // WB producers are covered by register-file write-through.
      hazard = (RegWriteE && match_e) || (RegWriteM && match_m);
    end
  end

  assign StallF = hazard;
  assign StallD = hazard;
  assign FlushE = hazard;

endmodule

// File: rtl/hazard_datapath.sv
// Five-stage IF/ID/EX/MEM/WB datapath with MEM/WB forwarding, load-use
// interlock, and an optional stall-only interlock build (FWD_EN=0).
module hazard_datapath
  import rsa_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FWD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic             ALUSrc,
  input  logic             MemtoReg,
  input  logic             MemWrite,
  input  logic             FlagsWriteD,
  input  logic             RegSrc,
  input  logic [2:0]       ALUControl,
  input  logic [31:0]      InstrF,
  input  logic [WIDTH-1:0] ReadData,
  output logic [31:0]      InstrD,
  output logic             StallF,
  output logic             MemWriteM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic             FlagsWriteW,
  output logic [3:0]       ALUFlagsW
);

  logic [3:0]       RnD, RdD, RA2D;
  logic [WIDTH-1:0] ExtImmD, RD1D, RD2D, ResultW;
  logic             StallD, FlushE;
  fwd_sel_e         ForwardAE, ForwardBE;

  logic             RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagsWriteE;
  alu_op_e          ALUControlE;
  logic [3:0]       RA1E, RA2E, WA3E;
  logic [WIDTH-1:0] RD1E, RD2E, ExtImmE;

  logic [WIDTH-1:0] SrcAE, SrcBE, WriteDataE, alu_y;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [3:0]       flags_e;

  logic             RegWriteM, MemtoRegM, FlagsWriteM;
  logic [3:0]       WA3M, FlagsM;

  logic             RegWriteW, MemtoRegW;
  logic [3:0]       WA3W;
  logic [WIDTH-1:0] ALUOutW, ReadDataW;

  logic [WIDTH-1:0] rf [16];

  assign RnD  = InstrD[RN_LSB +: 4];
  assign RdD  = InstrD[RD_LSB +: 4];
  assign RA2D = RegSrc ? RdD : InstrD[RM_LSB +: 4];

  generate
    if (WIDTH > IMM_W) begin : g_ext
      assign ExtImmD = {{(WIDTH-IMM_W){1'b0}}, InstrD[IMM_W-1:0]};
    end else begin : g_trunc
      assign ExtImmD = InstrD[WIDTH-1:0];
    end
  endgenerate

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
  assign RD1D    = (RegWriteW && (WA3W == RnD))  ? ResultW : rf[RnD];
  assign RD2D    = (RegWriteW && (WA3W == RA2D)) ? ResultW : rf[RA2D];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (RegWriteW) begin
      rf[WA3W] <= ResultW;
    end
  end

  hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
    .RnD       (RnD),
    .RA2D      (RA2D),
    .RA1E      (RA1E),
    .RA2E      (RA2E),
    .WA3E      (WA3E),
    .WA3M      (WA3M),
    .WA3W      (WA3W),
    .RegWriteE (RegWriteE),
    .MemtoRegE (MemtoRegE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE)
  );

  always_ff @(posedge clk) begin
    if (reset)       InstrD <= '0;
    else if (!StallD) InstrD <= InstrF;
  end

  // A flush clears the whole ID/EX slot so the bubble carries no controls.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      FlagsWriteE <= 1'b0;
      ALUControlE <= ALU_ADD;
      RA1E        <= '0;
      RA2E        <= '0;
      WA3E        <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ExtImmE     <= '0;
    end else begin
      RegWriteE   <= RegWrite;
      MemtoRegE   <= MemtoReg;
      MemWriteE   <= MemWrite;
      ALUSrcE     <= ALUSrc;
      FlagsWriteE <= FlagsWriteD;
      ALUControlE <= alu_op_e'(ALUControl);
      RA1E        <= RnD;
      RA2E        <= RA2D;
      WA3E        <= RdD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ExtImmE     <= ExtImmD;
    end
  end

  always_comb begin
    case (ForwardAE)
      FWD_MEM: SrcAE = ALUOutM;
      FWD_WB:  SrcAE = ResultW;
      default: SrcAE = RD1E;
    endcase
    case (ForwardBE)
      FWD_MEM: WriteDataE = ALUOutM;
      FWD_WB:  WriteDataE = ResultW;
      default: WriteDataE = RD2E;
    endcase
  end

  assign SrcBE    = ALUSrcE ? ExtImmE : WriteDataE;
  assign sum_ext  = {1'b0, SrcAE} + {1'b0, SrcBE};
  assign diff_ext = {1'b0, SrcAE} - {1'b0, SrcBE};

  always_comb begin
    alu_y   = '0;
    flags_e = '0;
    case (ALUControlE)
      ALU_ADD: begin
        alu_y           = sum_ext[WIDTH-1:0];
        flags_e[FLAG_C] = sum_ext[WIDTH];
        flags_e[FLAG_V] = (SrcAE[WIDTH-1] == SrcBE[WIDTH-1]) &&
                          (alu_y[WIDTH-1] != SrcAE[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_y           = diff_ext[WIDTH-1:0];
        flags_e[FLAG_C] = ~diff_ext[WIDTH];
        flags_e[FLAG_V] = (SrcAE[WIDTH-1] != SrcBE[WIDTH-1]) &&
                          (alu_y[WIDTH-1] != SrcAE[WIDTH-1]);
      end
      ALU_AND:   alu_y = SrcAE & SrcBE;
      ALU_ORR:   alu_y = SrcAE | SrcBE;
      ALU_EOR:   alu_y = SrcAE ^ SrcBE;
      ALU_LSL:   alu_y = SrcAE << SrcBE[4:0];
      ALU_LSR:   alu_y = SrcAE >> SrcBE[4:0];
      ALU_PASSB: alu_y = SrcBE;
    endcase
    flags_e[FLAG_N] = alu_y[WIDTH-1];
    flags_e[FLAG_Z] = (alu_y == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM   <= 1'b0;
      MemtoRegM   <= 1'b0;
      MemWriteM   <= 1'b0;
      FlagsWriteM <= 1'b0;
      ALUOutM     <= '0;
      WriteDataM  <= '0;
      WA3M        <= '0;
      FlagsM      <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemtoRegM   <= MemtoRegE;
      MemWriteM   <= MemWriteE;
      FlagsWriteM <= FlagsWriteE;
      ALUOutM     <= alu_y;
      WriteDataM  <= WriteDataE;
      WA3M        <= WA3E;
      FlagsM      <= flags_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      FlagsWriteW <= 1'b0;
      ALUOutW     <= '0;
      ReadDataW   <= '0;
      WA3W        <= '0;
      ALUFlagsW   <= '0;
    end else begin
      RegWriteW   <= RegWriteM;
      MemtoRegW   <= MemtoRegM;
      FlagsWriteW <= FlagsWriteM;
      ALUOutW     <= ALUOutM;
      ReadDataW   <= ReadData;
      WA3W        <= WA3M;
      ALUFlagsW   <= FlagsM;
    end
  end

endmodule
